// File: rtl/monster_fire_scheduler.sv
// monster_fire_scheduler: frame-paced missile arbiter with an in-flight cap and a global cooldown.
// Define MONSTER_FIRE_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest eligible index wins.
module monster_fire_scheduler #(
   parameter int MONSTER_AMOUNT  = 16,
   parameter int AMOUNT_WIDTH    = 4,
   parameter int COUNT_WIDTH     = 5,
   parameter int COOLDOWN_FRAMES = 3
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      enable,
   input  logic                      startOfFrame,
   input  logic                      stage_clear,
   input  logic [MONSTER_AMOUNT-1:0] shoot_request,
   input  logic [MONSTER_AMOUNT-1:0] monster_deactivated,
   input  logic [MONSTER_AMOUNT-1:0] missile_done,
   input  logic [COUNT_WIDTH-1:0]    max_missiles,
   output logic [MONSTER_AMOUNT-1:0] shoot_grant,
   output logic [AMOUNT_WIDTH-1:0]   grant_index,
   output logic [MONSTER_AMOUNT-1:0] in_flight,
   output logic [COUNT_WIDTH-1:0]    missiles_in_flight
);
   localparam int CD_W = COOLDOWN_FRAMES > 1 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
   typedef enum logic [1:0] {READY, GRANT, COOLDOWN} state_t;
   state_t state, state_nx;
   logic [MONSTER_AMOUNT-1:0] eligible;
   logic [AMOUNT_WIDTH-1:0]   sel, sel_nx, pick;
   logic [CD_W-1:0]           cnt, cnt_nx;
   logic [COUNT_WIDTH-1:0]    pop;
   logic                      launch;
   assign eligible = shoot_request & ~monster_deactivated & ~in_flight;
   assign launch = startOfFrame && enable && (missiles_in_flight < max_missiles) && |eligible;
   assign shoot_grant = (state == GRANT && !stage_clear) ? MONSTER_AMOUNT'(1) << sel : '0;
`ifdef MONSTER_FIRE_ROUND_ROBIN_EN
   logic [AMOUNT_WIDTH-1:0] rr_ptr, idx;
   // Scanning downward lets the closest index at or after rr_ptr overwrite the others.
   always_comb begin
      pick = '0;
      idx = '0;
      for (int k = MONSTER_AMOUNT - 1; k >= 0; k--) begin
         idx = AMOUNT_WIDTH'((int'(rr_ptr) + k) % MONSTER_AMOUNT);
         if (eligible[idx]) pick = idx;
      end
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) rr_ptr <= '0;
      else if (stage_clear) rr_ptr <= '0;
      else if (state == GRANT) rr_ptr <= (int'(sel) == MONSTER_AMOUNT - 1) ? '0 : sel + 1'b1;
`else
   always_comb begin
      pick = '0;
      for (int k = MONSTER_AMOUNT - 1; k >= 0; k--)
         if (eligible[k]) pick = AMOUNT_WIDTH'(k);
   end
`endif
   always_comb begin
      pop = '0;
      for (int k = 0; k < MONSTER_AMOUNT; k++) pop = pop + COUNT_WIDTH'(in_flight[k]);
   end
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      sel_nx = sel;
      if (stage_clear) begin
         state_nx = READY;
         cnt_nx = '0;
      end else begin
         case (state)
            READY: if (launch) begin
               state_nx = GRANT;
               sel_nx = pick;
            end
            GRANT: begin
               cnt_nx = CD_W'(COOLDOWN_FRAMES);
               state_nx = (COOLDOWN_FRAMES == 0) ? READY : COOLDOWN;
            end
            COOLDOWN: if (startOfFrame && enable) begin
               cnt_nx = cnt - 1'b1;
               state_nx = (cnt == CD_W'(1)) ? READY : COOLDOWN;
            end
            default: state_nx = READY;
         endcase
      end
   end
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         state <= READY;
         cnt <= '0;
         sel <= '0;
         in_flight <= '0;
         missiles_in_flight <= '0;
         grant_index <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         sel <= sel_nx;
         in_flight <= stage_clear ? '0 : (in_flight & ~missile_done) | shoot_grant;
         missiles_in_flight <= stage_clear ? '0 : pop;
         if (shoot_grant != '0) grant_index <= sel;
      end
endmodule
